// File: rtl/pixel_pack_writer_if.sv
// ============================================================================
// Module     : pixel_pack_writer_if
// Purpose    : Groups the pixel stream that feeds the packer and the BRAM
//              write port it drives.
// Ports      : data_valid_in, pixel_data_in, hcount_in, vcount_in
//                (pixel source -> packer)
//              we_out, waddr_out, wdata_out, frame_done_out, err_out
//                (packer -> frame buffer / status)
// Modports   : master - pixel source side (drives the stream, observes writes)
//              slave  - packer side
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pixel_pack_writer_if #(
  parameter int WORD_W = 16,
  parameter int ADDR_W = 13
) ();
  logic              data_valid_in;
  logic              pixel_data_in;
  logic [10:0]       hcount_in;
  logic [9:0]        vcount_in;
  logic              we_out;
  logic [ADDR_W-1:0] waddr_out;
  logic [WORD_W-1:0] wdata_out;
  logic              frame_done_out;
  logic              err_out;

  modport master (
    output data_valid_in, pixel_data_in, hcount_in, vcount_in,
    input  we_out, waddr_out, wdata_out, frame_done_out, err_out
  );

  modport slave (
    input  data_valid_in, pixel_data_in, hcount_in, vcount_in,
    output we_out, waddr_out, wdata_out, frame_done_out, err_out
  );
endinterface

`default_nettype wire

// File: rtl/pixel_pack_writer.sv
// ============================================================================
// Module     : pixel_pack_writer
// Purpose    : Packs a stream of 1-bit pixels into WORD_W-bit words and issues
//              one frame-buffer write per word. Writing begins only at a frame
//              start (pixel 0,0); the write of the last word of the frame is
//              flagged with frame_done_out.
// Ports      : clk_in  - system clock, rising edge
//              rst_in  - asynchronous reset, active low
//              bus     - pixel_pack_writer_if.slave (pixel stream in,
//                        BRAM write port and status out)
// Config     : PACK_MSB_FIRST_EN - when defined, pixel with bit index 0 lands
//              in wdata[WORD_W-1]; otherwise it lands in wdata[0].
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module pixel_pack_writer #(
  parameter int H_ACTIVE = 320,
  parameter int V_ACTIVE = 240,
  parameter int WORD_W   = 16,
  parameter int ADDR_W   = 13
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  pixel_pack_writer_if.slave   bus
);

  localparam int LOG2W     = $clog2(WORD_W);
  localparam int WPL       = H_ACTIVE / WORD_W;
  localparam int LAST_WORD = (H_ACTIVE * V_ACTIVE / WORD_W) - 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LAST_WORD);

  typedef enum logic [0:0] {
    WAIT_SOF = 1'b0,
    PACK     = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] acc_q, acc_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              fd_q, fd_d;
  logic              err_q, err_d;

  logic              accept;
  logic              sof;
  logic [LOG2W-1:0]  bidx;
  logic [LOG2W-1:0]  bpos;
  logic [ADDR_W-1:0] addr;
  logic [WORD_W-1:0] bit_val;
  logic              fresh;
  logic              flush_partial;
  logic [WORD_W-1:0] merged;

  assign accept = bus.data_valid_in
                  && (32'(bus.hcount_in) < 32'(H_ACTIVE))
                  && (32'(bus.vcount_in) < 32'(V_ACTIVE));
  assign sof    = accept && (bus.hcount_in == 11'd0) && (bus.vcount_in == 10'd0);
  assign bidx   = bus.hcount_in[LOG2W-1:0];

  // Word address. Evaluating the sum directly at ADDR_W bits gives the same
  // result as computing it wide and truncating (arithmetic is modulo 2**ADDR_W).
  assign addr = ADDR_W'(bus.vcount_in) * ADDR_W'(WPL)
              + ADDR_W'(bus.hcount_in >> LOG2W);

`ifdef PACK_MSB_FIRST_EN
  // WORD_W is a power of two, so WORD_W-1-b is the bitwise complement of b.
  assign bpos = ~bidx;
`else
  assign bpos = bidx;
`endif

  assign bit_val = {{(WORD_W-1){1'b0}}, bus.pixel_data_in} << bpos;

  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    pend_d        = pend_q;
    paddr_d       = paddr_q;
    we_d          = 1'b0;
    waddr_d       = waddr_q;
    wdata_d       = wdata_q;
    fd_d          = 1'b0;
    err_d         = err_q;
    // A pixel opens a fresh word on a frame start, when nothing is pending,
    // or when it belongs to a different word than the pending partial.
    fresh         = sof || !pend_q || (addr != paddr_q);
    merged        = (fresh ? '0 : acc_q) | bit_val;
    // A pending partial leaves because a pixel of another word arrived
    // (a frame start discards it instead).
    flush_partial = pend_q && fresh && !sof;

    if (accept && ((state_q == PACK) || sof)) begin
      state_d = PACK;
      if (sof && pend_q) begin
        err_d = 1'b1;
      end
      if (&bidx) begin
        // Word completes this cycle; it takes the single write slot, so any
        // outgoing partial is lost.
        we_d    = 1'b1;
        waddr_d = addr;
        wdata_d = merged;
        acc_d   = '0;
        pend_d  = 1'b0;
        if (flush_partial) begin
          err_d = 1'b1;
        end
      end else begin
        acc_d   = merged;
        pend_d  = 1'b1;
        paddr_d = addr;
        if (flush_partial) begin
          we_d    = 1'b1;
          waddr_d = paddr_q;
          wdata_d = acc_q;
        end
      end
      // Writing the last word closes the frame; nothing carries over.
      if (we_d && (waddr_d == LAST_ADDR)) begin
        fd_d    = 1'b1;
        state_d = WAIT_SOF;
        acc_d   = '0;
        pend_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= WAIT_SOF;
      acc_q   <= '0;
      pend_q  <= 1'b0;
      paddr_q <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      fd_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      pend_q  <= pend_d;
      paddr_q <= paddr_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      fd_q    <= fd_d;
      err_q   <= err_d;
    end
  end

  assign bus.we_out         = we_q;
  assign bus.waddr_out      = waddr_q;
  assign bus.wdata_out      = wdata_q;
  assign bus.frame_done_out = fd_q;
  assign bus.err_out        = err_q;

endmodule

`default_nettype wire

// File: tb/tb_pixel_pack_writer.sv
// ============================================================================
// Module     : tb_pixel_pack_writer
// Purpose    : Self-checking bench for pixel_pack_writer. Expected writes are
//              queued when the last pixel of a word is driven and compared
//              when the DUT writes.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pixel_pack_writer;

  localparam int H    = 320;
  localparam int V    = 240;
  localparam int W    = 16;
  localparam int AW   = 13;
  localparam int WPL  = 20;
  localparam int LAST = 4799;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  pixel_pack_writer_if #(.WORD_W(W), .ADDR_W(AW)) bus ();

  pixel_pack_writer #(
    .H_ACTIVE (H),
    .V_ACTIVE (V),
    .WORD_W   (W),
    .ADDR_W   (AW)
  ) dut (
    .clk_in (clk),
    .rst_in (rst_n),
    .bus    (bus)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
    logic          fd;
    int unsigned   cyc;
  } exp_t;

  typedef struct {
    int           v;
    int           w;
    logic [W-1:0] pat;
    int           exp_addr;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[6];
  int compared   = 0;
  int mismatched = 0;

  function automatic logic [W-1:0] pack_exp(input logic [W-1:0] pat);
    logic [W-1:0] r;
`ifdef PACK_MSB_FIRST_EN
    for (int i = 0; i < W; i++) r[W-1-i] = pat[i];
`else
    r = pat;
`endif
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_px(input int h, input int v, input logic p, input logic vld = 1'b1);
    @(posedge clk);
    #1;
    bus.data_valid_in = vld;
    bus.hcount_in     = 11'(h);
    bus.vcount_in     = 10'(v);
    bus.pixel_data_in = p;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      bus.data_valid_in = 1'b0;
    end
  endtask

  // Called in the same time step as the drive of a word's final pixel:
  // the write must appear one clock later.
  task automatic push_exp(input int addr, input logic [W-1:0] data);
    exp_t e;
    e.addr = AW'(addr);
    e.data = data;
    e.fd   = (addr == LAST);
    e.cyc  = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic drive_word(input int v, input int w, input logic [W-1:0] pat, input int exp_addr);
    for (int i = 0; i < W; i++) begin
      drive_px(w * W + i, v, pat[i]);
      if (i == W - 1) push_exp(exp_addr, pack_exp(pat));
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_we"},    32'(bus.we_out),         32'd0);
    check({tag, "_waddr"}, 32'(bus.waddr_out),      32'd0);
    check({tag, "_wdata"}, 32'(bus.wdata_out),      32'd0);
    check({tag, "_fd"},    32'(bus.frame_done_out), 32'd0);
    check({tag, "_err"},   32'(bus.err_out),        32'd0);
  endtask

  initial begin
    vecs[0] = '{v: 0,   w: 1,  pat: 16'hA5A5, exp_addr: 1};
    vecs[1] = '{v: 3,   w: 7,  pat: 16'h8001, exp_addr: 67};
    vecs[2] = '{v: 100, w: 19, pat: 16'h1234, exp_addr: 2019};
    vecs[3] = '{v: 239, w: 0,  pat: 16'h7FFE, exp_addr: 4780};
    vecs[4] = '{v: 239, w: 18, pat: 16'hC3C3, exp_addr: 4798};
    vecs[5] = '{v: 239, w: 19, pat: 16'h0F0F, exp_addr: 4799};

    bus.data_valid_in = 1'b0;
    bus.pixel_data_in = 1'b0;
    bus.hcount_in     = '0;
    bus.vcount_in     = '0;
    rst_n             = 1'b0;

    // Write monitor: every DUT write must match the head of the scoreboard.
    fork
      forever begin
        exp_t e;
        @(negedge clk);
        if (rst_n) begin
          if (bus.we_out) begin
            if (sb.size() == 0) begin
              compared++;
              mismatched++;
              $display("FAIL unexpected_write: addr %0d data 0x%0h, no write expected (t=%0t)",
                       bus.waddr_out, bus.wdata_out, $time);
            end else begin
              e = sb.pop_front();
              check("waddr",      32'(bus.waddr_out),      32'(e.addr));
              check("wdata",      32'(bus.wdata_out),      32'(e.data));
              check("frame_done", 32'(bus.frame_done_out), 32'(e.fd));
              check("latency",    cyc,                     e.cyc);
            end
          end else if (bus.frame_done_out) begin
            compared++;
            mismatched++;
            $display("FAIL stray_frame_done: got 1 without a write, expected 0 (t=%0t)", $time);
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst_n = 1'b1;

    // Released mid-frame: nothing is written until pixel (0,0).
    for (int h = 40; h < H; h++) drive_px(h, 10, 1'b1);
    for (int h = 0; h < 8; h++) drive_px(h, 11, 1'b1);

    // Frame start; pixel = (hcount==3) in word 0.
    drive_word(0, 0, 16'h0008, 0);

    // Table of words, ending with the last word of the frame.
    for (int i = 0; i < 6; i++) drive_word(vecs[i].v, vecs[i].w, vecs[i].pat, vecs[i].exp_addr);
    idle(2);
    check("err_after_table", 32'(bus.err_out), 32'd0);

    // New frame; row 5 gets hcount 16..19 then valid drops for 20..31.
    drive_word(0, 0, 16'h0000, 0);
    for (int h = 16; h < 20; h++) drive_px(h, 5, 1'b1);
    idle(12);
    drive_px(0, 6, 1'b1);
    push_exp(101, pack_exp(16'h000F));
    for (int h = 1; h < W; h++) drive_px(h, 6, 1'b1);
    push_exp(120, 16'hFFFF);

    // Out-of-range and invalid pixels are ignored.
    drive_px(320, 5, 1'b1);
    drive_px(0, 240, 1'b1);
    drive_px(400, 250, 1'b1);
    drive_px(0, 0, 1'b1, 1'b0);
    idle(2);
    check("err_no_discard", 32'(bus.err_out), 32'd0);

    // New frame after 7 pixels of a word: partial discarded, err sticky.
    for (int h = 0; h < 7; h++) drive_px(h, 7, 1'b1);
    drive_px(0, 0, 1'b1);
    for (int h = 1; h < W; h++) drive_px(h, 0, 1'b1);
    push_exp(0, 16'hFFFF);
    idle(2);
    check("err_set", 32'(bus.err_out), 32'd1);
    idle(5);
    check("err_sticky", 32'(bus.err_out), 32'd1);

    // Full frame of ones with continuous valid.
    for (int v = 0; v < V; v++) begin
      for (int h = 0; h < H; h++) begin
        drive_px(h, v, 1'b1);
        if ((h % W) == W - 1) push_exp(v * WPL + h / W, 16'hFFFF);
      end
    end
    idle(3);
    check("queue_drained_frame", 32'(sb.size()), 32'd0);

    // Async reset asserted while a write is on the port.
    for (int h = 0; h < W; h++) drive_px(h, 0, 1'b1);
    @(posedge clk);
    #1;
    bus.data_valid_in = 1'b0;
    check("we_before_reset", 32'(bus.we_out), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("async_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Back in WAIT_SOF: row 1 is ignored, frame start resumes writing.
    for (int h = 0; h < W; h++) drive_px(h, 1, 1'b1);
    drive_word(0, 0, 16'h8001, 0);
    idle(3);
    check("queue_drained_end", 32'(sb.size()), 32'd0);
    check("err_after_reset",   32'(bus.err_out), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
